// File: rtl/aib_tx_framer.sv
// aib_tx_framer
// TX-side framing stage that feeds the 80-bit tx_data bus of the AIB channel
// wrapper. Fabric payload words (64-bit + last marker) arrive over a
// valid/ready handshake and are buffered in a small in-order FIFO. Every clock
// one registered 80-bit frame is emitted: TRAIN_LEN training frames after
// reset, then data, idle or periodic alignment frames.
//
// Frame layout (index 0 is the first/leftmost bit):
//   [0:1]   header   01 data, 10 control
//   [2:65]  payload
//   [66:73] seq      data frames only
//   [74]    last     data frames only
//   [75:78] ctrl     0001 train, 0010 align, 0100 idle, 0000 data
//   [79]    parity   even parity over [0:78] when AIB_TX_PARITY_EN is defined,
//                    constant 0 otherwise
//
// Ports:
//   tx_clk    in   clock (AIB tx_clk)
//   reset     in   asynchronous active-high reset
//   tx_en     in   when low in RUN no FIFO pops happen
//   in_valid  in   payload word valid
//   in_ready  out  FIFO can accept a word (registered, !full)
//   in_data   in   [0:63] payload word
//   in_last   in   end-of-packet marker carried with the word
//   tx_data   out  [0:79] registered frame
//   trained   out  high while in RUN state
//
// Optional feature macro: AIB_TX_PARITY_EN
module aib_tx_framer #(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          TRAIN_LEN     = 16,
    parameter int          ALIGN_PERIOD  = 256,
    parameter logic [63:0] ALIGN_PATTERN = 64'hA5A5_A5A5_A5A5_A5A5
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_data,
    input  logic        in_last,
    output logic [0:79] tx_data,
    output logic        trained
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TRN_W = $clog2(TRAIN_LEN + 1);
    localparam int FC_W  = $clog2(ALIGN_PERIOD);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [TRN_W-1:0] TRAIN_LAST = TRN_W'(TRAIN_LEN - 1);
    localparam logic [FC_W-1:0]  ALIGN_LAST = FC_W'(ALIGN_PERIOD - 1);

    localparam logic [63:0] TRAIN_PAYLOAD = 64'h5555_5555_5555_5555;
    localparam logic [1:0]  HDR_DATA      = 2'b01;
    localparam logic [1:0]  HDR_CTRL      = 2'b10;
    localparam logic [3:0]  CT_TRAIN      = 4'b0001;
    localparam logic [3:0]  CT_ALIGN      = 4'b0010;
    localparam logic [3:0]  CT_IDLE       = 4'b0100;

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

`ifdef AIB_TX_PARITY_EN
    // Even parity: bit 79 makes the popcount of the whole frame even.
    function automatic logic frame_parity(input logic [0:78] f);
        return ^f;
    endfunction
`endif

    state_t            state_q, state_d;
    logic [TRN_W-1:0]  train_cnt_q, train_cnt_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]        seq_q, seq_d;
    logic [0:79]       tx_data_q, tx_data_d;
    logic              trained_q, trained_d;
    logic              in_ready_q, in_ready_d;

    // FIFO entry = {last, payload}
    logic [64:0]       mem_q [FIFO_DEPTH];
    logic [64:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              push_s;
    logic              pop_s;
    logic [64:0]       entry_s;

    assign push_s = in_valid & in_ready_q;

    // Frame selection and framing state: train, align, data or idle.
    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        frame_cnt_d = frame_cnt_q;
        seq_d       = seq_q;
        pop_s       = 1'b0;
        entry_s     = mem_q[rd_ptr_q];
        tx_data_d   = '0;
        trained_d   = (state_q == ST_RUN);
        case (state_q)
            ST_TRAIN: begin
                tx_data_d[0:1]   = HDR_CTRL;
                tx_data_d[2:65]  = TRAIN_PAYLOAD;
                tx_data_d[75:78] = CT_TRAIN;
                if (train_cnt_q == TRAIN_LAST) begin
                    state_d     = ST_RUN;
                    train_cnt_d = '0;
                end else begin
                    train_cnt_d = train_cnt_q + TRN_W'(1);
                end
            end
            ST_RUN: begin
                if (frame_cnt_q == ALIGN_LAST) begin
                    // Align wins over a pending pop; the pop simply waits one cycle.
                    tx_data_d[0:1]   = HDR_CTRL;
                    tx_data_d[2:65]  = ALIGN_PATTERN;
                    tx_data_d[75:78] = CT_ALIGN;
                    frame_cnt_d      = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    if (tx_en && (cnt_q != {CNT_W{1'b0}})) begin
                        pop_s             = 1'b1;
                        tx_data_d[0:1]    = HDR_DATA;
                        tx_data_d[2:65]   = entry_s[63:0];
                        tx_data_d[66:73]  = seq_q;
                        tx_data_d[74]     = entry_s[64];
                        seq_d             = seq_q + 8'd1;
                    end else begin
                        tx_data_d[0:1]   = HDR_CTRL;
                        tx_data_d[75:78] = CT_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_TRAIN;
            end
        endcase
`ifdef AIB_TX_PARITY_EN
        tx_data_d[79] = frame_parity(tx_data_d[0:78]);
`else
        tx_data_d[79] = 1'b0;
`endif
    end

    // Payload FIFO bookkeeping: in-order storage, no bypass path.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {in_last, in_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // Ready reflects the occupancy the FIFO will have after this edge.
        in_ready_d = (cnt_d != DEPTH_C);
    end

    // State, FIFO and output registers.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_TRAIN;
            train_cnt_q <= '0;
            frame_cnt_q <= '0;
            seq_q       <= 8'd0;
            tx_data_q   <= '0;
            trained_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            seq_q       <= seq_d;
            tx_data_q   <= tx_data_d;
            trained_q   <= trained_d;
            in_ready_q  <= in_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign trained  = trained_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_aib_tx_framer.sv
// Self-checking bench for aib_tx_framer (built with ALIGN_PERIOD = 8).
// Stimulus pushes the expected {last, seq, payload} of every accepted word
// into a queue; a monitor checks every frame on the falling edge and pops the
// queue on each data frame.
module tb_aib_tx_framer;

    localparam int TRAIN_LEN    = 16;
    localparam int ALIGN_PERIOD = 8;

    logic        tx_clk;
    logic        reset;
    logic        tx_en;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_data;
    logic        in_last;
    logic [0:79] tx_data;
    logic        trained;

    int n_vec  = 0;
    int n_fail = 0;

    logic [72:0] exp_q [$];
    logic [7:0]  exp_seq = 8'd0;
    logic        live;
    logic        saw_wrap = 1'b0;

    aib_tx_framer #(
        .FIFO_DEPTH   (4),
        .TRAIN_LEN    (TRAIN_LEN),
        .ALIGN_PERIOD (ALIGN_PERIOD),
        .ALIGN_PATTERN(64'hA5A5_A5A5_A5A5_A5A5)
    ) dut (
        .tx_clk  (tx_clk),
        .reset   (reset),
        .tx_en   (tx_en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_last (in_last),
        .tx_data (tx_data),
        .trained (trained)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    // live goes high once a frame has been clocked out since the last reset
    always @(posedge tx_clk or posedge reset) begin
        if (reset) live <= 1'b0;
        else       live <= 1'b1;
    end

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: checks every frame after reset release.
    initial begin : monitor
        logic [0:79] f;
        logic        in_run;
        int          tr_cnt;
        int          fc;
        logic [7:0]  prev_seq;
        logic        exp_par;
        logic [72:0] e;
        in_run   = 1'b0;
        tr_cnt   = 0;
        fc       = 0;
        prev_seq = 8'd0;
        forever begin
            @(negedge tx_clk);
            if (reset || !live) begin
                in_run = 1'b0;
                tr_cnt = 0;
                fc     = 0;
            end else begin
                f = tx_data;
`ifdef AIB_TX_PARITY_EN
                exp_par = ^f[0:78];
`else
                exp_par = 1'b0;
`endif
                chk("parity", {79'd0, f[79]}, {79'd0, exp_par});
                if (!in_run && f[0:1] == 2'b10 && f[75:78] == 4'b0001) begin
                    tr_cnt++;
                    chk("train_payload", {16'd0, f[2:65]}, {16'd0, 64'h5555_5555_5555_5555});
                    chk("train_trained", {79'd0, trained}, 80'd0);
                end else begin
                    if (!in_run) begin
                        chk("train_len", 80'(tr_cnt), 80'(TRAIN_LEN));
                        in_run = 1'b1;
                    end
                    chk("run_trained", {79'd0, trained}, {79'd0, 1'b1});
                    if (fc == ALIGN_PERIOD - 1) begin
                        fc = 0;
                        chk("align_frame", 80'({f[0:1], f[2:65], f[66:78]}),
                            80'({2'b10, 64'hA5A5_A5A5_A5A5_A5A5, 9'd0, 4'b0010}));
                    end else begin
                        fc++;
                        if (f[0:1] == 2'b01) begin
                            chk("data_ctrl", {76'd0, f[75:78]}, 80'd0);
                            if (exp_q.size() == 0) begin
                                chk("unexpected_data", {7'd0, f[74], f[66:73], f[2:65]}, 80'd0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("data_word", {7'd0, f[74], f[66:73], f[2:65]}, {7'd0, e});
                                if (prev_seq == 8'd255 && f[66:73] == 8'd0) saw_wrap = 1'b1;
                                prev_seq = f[66:73];
                            end
                        end else begin
                            chk("idle_frame", 80'({f[0:1], f[2:65], f[66:78]}),
                                80'({2'b10, 64'd0, 9'd0, 4'b0100}));
                        end
                    end
                end
            end
        end
    end

    // Offer one word (call at a negedge); returns at the negedge after acceptance.
    task automatic push_word(input logic [63:0] d, input logic l);
        int waitc = 0;
        while (!in_ready && waitc < 200) begin
            @(negedge tx_clk);
            waitc++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {79'd0, in_ready}, {79'd0, 1'b1});
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = l;
            @(negedge tx_clk);
            exp_q.push_back({l, exp_seq, d});
            exp_seq  = exp_seq + 8'd1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 100) begin
            @(negedge tx_clk);
            waitc++;
        end
        chk("drain", 80'(exp_q.size()), 80'd0);
    endtask

    initial begin : stim
        int waitc;
        reset    = 1'b1;
        tx_en    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge tx_clk);
        chk("rst_tx_data", 80'(tx_data), 80'd0);
        chk("rst_in_ready", {79'd0, in_ready}, 80'd0);
        chk("rst_trained", {79'd0, trained}, 80'd0);
        @(posedge tx_clk);
        #2 reset = 1'b0;
        @(posedge tx_clk);
        @(negedge tx_clk);
        chk("ready_after_rst", {79'd0, in_ready}, {79'd0, 1'b1});

        // Training then idle
        waitc = 0;
        while (!trained && waitc < 40) begin
            @(negedge tx_clk);
            waitc++;
        end
        chk("trained_rise", {79'd0, trained}, {79'd0, 1'b1});
        chk("first_idle", 80'({tx_data[0:1], tx_data[2:65], tx_data[75:78]}),
            80'({2'b10, 64'd0, 4'b0100}));

        // Latency: start right after an align frame so none intervenes
        waitc = 0;
        while (tx_data[75:78] != 4'b0010 && waitc < 40) begin
            @(negedge tx_clk);
            waitc++;
        end
        chk("align_seen", {76'd0, tx_data[75:78]}, {76'd0, 4'b0010});
        push_word(64'h1, 1'b0);
        push_word(64'h2, 1'b0);
        chk("lat_w1", 80'({tx_data[0:1], tx_data[2:65]}), 80'({2'b01, 64'h1}));
        push_word(64'h3, 1'b1);
        chk("lat_w2", 80'({tx_data[0:1], tx_data[2:65]}), 80'({2'b01, 64'h2}));
        @(negedge tx_clk);
        chk("lat_w3", 80'({tx_data[0:1], tx_data[2:65], tx_data[74]}), 80'({2'b01, 64'h3, 1'b1}));
        drain();

        // Back-pressure with tx_en low
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(64'h1000 + 64'(i), 1'b0);
        chk("ready_full", {79'd0, in_ready}, 80'd0);
        repeat (3) @(negedge tx_clk);
        chk("ready_held", {79'd0, in_ready}, 80'd0);
        chk("no_pop_tx_en_low", 80'(exp_q.size()), 80'd4);
        tx_en = 1'b1;
        push_word(64'h1004, 1'b1);
        drain();

        // Continuous stream of 20 words through align frames
        for (int i = 0; i < 20; i++) push_word(64'h2000 + 64'(i), (i == 19));
        drain();

        // 258-word stream: seq wraps
        for (int i = 0; i < 258; i++) push_word({32'hC0DE_0000, 32'(i)}, (i % 10 == 9));
        drain();
        chk("seq_wrap_seen", {79'd0, saw_wrap}, {79'd0, 1'b1});

        // Reset with three words buffered
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) push_word(64'hDEAD_0000 + 64'(i), 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx_data", 80'(tx_data), 80'd0);
        chk("async_rst_in_ready", {79'd0, in_ready}, 80'd0);
        chk("async_rst_trained", {79'd0, trained}, 80'd0);
        exp_q.delete();
        exp_seq = 8'd0;
        repeat (2) @(negedge tx_clk);
        @(posedge tx_clk);
        #2 reset = 1'b0;
        tx_en = 1'b1;
        @(negedge tx_clk);
        push_word(64'h7777_0000, 1'b0);
        push_word(64'h7777_0001, 1'b1);
        drain();
        repeat (4) @(negedge tx_clk);
        chk("post_rst_trained", {79'd0, trained}, {79'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/aib_tx_framer.md
Name: aib_tx_framer

Overview:
- TX-side framing stage that directly feeds the 80-bit tx_data bus of the AIB channel wrapper.
- Accepts 64-bit payload words from fabric over a valid/ready handshake and buffers them in a small FIFO.
- Emits one 80-bit frame per clock: training frames after reset, then data, idle or periodic alignment frames, so the far-side receiver can lock and align.

Parameters:
- FIFO_DEPTH, 4, payload FIFO entries; power of two, >=2.
- TRAIN_LEN, 16, training frames emitted after reset; >=1.
- ALIGN_PERIOD, 256, RUN-state frames between alignment frames; >=2.
- ALIGN_PATTERN, 64'hA5A5_A5A5_A5A5_A5A5, payload of alignment frames.

Ports:
- tx_clk  input  1  single clock; same clock as the AIB tx_clk.
- reset  input  1  asynchronous, active-high reset.
- tx_en  input  1  when low in RUN, no FIFO pops (idle or align frames only).
- in_valid  input  1  payload word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  [0:63]  payload word.
- in_last  input  1  end-of-packet marker, carried with the word.
- tx_data  output  [0:79]  registered frame to the AIB tx_data.
- trained  output  1  high while in RUN state.

Behaviour:
- Frame fields:
  - [0:1] header: 01 = data, 10 = control.
  - [2:65] payload.
  - [66:73] seq: data frames only; 0 in control frames.
  - [74] last: data frames only.
  - [75:78] ctrl type: 0001 train, 0010 align, 0100 idle; 0000 in data frames.
  - [79] parity slot.
- Reset (async assert, sync use after release):
  - tx_data = 0, in_ready = 0, trained = 0.
  - FIFO empty, seq = 0, train count = 0, frame count = 0, state TRAIN.
  - Reset mid-stream discards all buffered words.
- in_ready = !fifo_full, registered-count based; independent of in_valid. It goes high the first cycle after reset deasserts.
- A word is accepted on any edge where in_valid & in_ready. It may be accepted in any state, including TRAIN.
- FIFO is strictly in-order with no bypass. A push while full is impossible (in_ready = 0). Simultaneous push and pop with the FIFO non-full are both performed.
- State TRAIN:
  - Each cycle emits a train frame with payload 64'h5555_5555_5555_5555.
  - After TRAIN_LEN train frames, go to RUN; trained rises with the first RUN frame.
- State RUN, per cycle:
  - If frame count == ALIGN_PERIOD-1: emit an align frame (payload ALIGN_PATTERN), no pop, frame count -> 0.
  - Else if tx_en and FIFO non-empty: pop and emit a data frame with the current seq. seq increments, wrapping 255 -> 0.
  - Else: emit an idle frame with payload 0.
  - Frame count increments on every non-align RUN frame.
- Latency: a word accepted on edge N into an empty FIFO in RUN, with tx_en high and no align due, is driven on tx_data from edge N+1.
- Align precedence: an align frame defers a pending pop by exactly one cycle. No payload is lost or reordered.
- No RUN -> TRAIN transition except via reset.

Optional Feature:
- Macro: AIB_TX_PARITY_EN.
- Defined: tx_data[79] = XOR of tx_data[0:78] (even parity over the whole frame), computed on every frame type, registered with the frame.
- Undefined: tx_data[79] is always 0; no parity logic is instantiated.

Test Plan:
- Release reset, in_valid = 0:
  - Exactly 16 frames with [0:1]=10, [75:78]=0001, payload 5555…; trained = 0 throughout.
  - Then idle frames ([75:78]=0100, payload 0) with trained = 1.
- After training, push words 64'h1, 64'h2, 64'h3 on consecutive cycles, in_last only on the third:
  - Data frames [0:1]=01 with seq 0, 1, 2, each one cycle after acceptance.
  - Bit 74 = 1 only on seq 2.
- tx_en = 0, offer 5 words:
  - in_ready drops after 4 accepts.
  - Raise tx_en: 4 frames in order, 5th accepted as space frees, 5 frames total, seq contiguous.
- ALIGN_PERIOD = 8, continuous stream of 20 words, tx_en = 1:
  - Align frame ([75:78]=0010, payload A5A5…) every 8th RUN frame.
  - All 20 words emitted in order, seq 0..19 without gaps.
- Stream 258 words:
  - seq wraps 255 -> 0 -> 1.
  - With AIB_TX_PARITY_EN, every frame has an even-parity popcount over [0:79].
  - Without it, bit 79 is always 0.
- Assert reset while the FIFO holds 3 words:
  - tx_data = 0 immediately (asynchronous), in_ready = 0.
  - After release, TRAIN restarts from count 0; the old words never appear; seq restarts at 0.
